// File: rtl/tpu_pkg.sv
// Shared definitions for the output-stationary systolic GEMM engine:
// FSM state encoding, default geometry and the C word-address helper.
package tpu_pkg;

    localparam int TPU_ARR = 4;   // systolic array edge
    localparam int TPU_DW  = 8;   // operand element width
    localparam int TPU_AW  = 32;  // accumulator / C element width
    localparam int TPU_IW  = 16;  // SRAM index width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } tpu_state_e;

    // C word for row `row` of output tile (mt, nt): column tiles are laid
    // out as consecutive blocks of M rows.
    function automatic logic [31:0] c_word_index(input logic [31:0] nt,
                                                 input logic [31:0] m,
                                                 input logic [31:0] mt,
                                                 input logic [31:0] row,
                                                 input logic [31:0] arr);
        return nt * m + mt * arr + row;
    endfunction

endpackage

// File: rtl/tpu_pe.sv
// One multiply-accumulate cell of the systolic array. Operands arriving
// from the left (a) and top (b) are multiplied into the accumulator and
// forwarded right/down through one register stage each.
module tpu_pe
    import tpu_pkg::*;
#(
    parameter int DW = TPU_DW,
    parameter int AW = TPU_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_signed,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_a,
    output logic [DW-1:0] o_b,
    output logic [AW-1:0] o_acc
);

    logic [AW-1:0] w_ext_a;
    logic [AW-1:0] w_ext_b;
    logic [AW-1:0] w_prod;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [AW-1:0] r_acc;

    assign w_ext_a = i_signed ? {{(AW-DW){i_a[DW-1]}}, i_a} : {{(AW-DW){1'b0}}, i_a};
    assign w_ext_b = i_signed ? {{(AW-DW){i_b[DW-1]}}, i_b} : {{(AW-DW){1'b0}}, i_b};
    // Product truncated to AW bits: accumulation wraps modulo 2^AW.
    assign w_prod  = w_ext_a * w_ext_b;

    // Forward operands and accumulate; clear has priority over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            r_a <= i_a;
            r_b <= i_b;
            if (i_clr) begin
                r_acc <= '0;
            end else begin
                r_acc <= r_acc + w_prod;
            end
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/tpu_gemm_engine.sv
// Output-stationary systolic GEMM engine: C = A x B over tile-packed SRAMs.
// Each tile streams K operand words through an ARR x ARR PE grid, then
// writes up to ARR C rows. Optional macro TPU_SIGNED_EN adds signed_mode,
// selecting two's-complement operands for the job.
module tpu_gemm_engine
    import tpu_pkg::*;
#(
    parameter int ARR = TPU_ARR,
    parameter int DW  = TPU_DW,
    parameter int AW  = TPU_AW,
    parameter int IW  = TPU_IW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        K,
    input  logic [7:0]        M,
    input  logic [7:0]        N,
`ifdef TPU_SIGNED_EN
    input  logic              signed_mode,
`endif
    output logic              busy,
    output logic              done,
    output logic [IW-1:0]     a_index,
    input  logic [ARR*DW-1:0] a_data_out,
    output logic              a_wr_en,
    output logic [ARR*DW-1:0] a_data_in,
    output logic [IW-1:0]     b_index,
    input  logic [ARR*DW-1:0] b_data_out,
    output logic              b_wr_en,
    output logic [ARR*DW-1:0] b_data_in,
    output logic              c_wr_en,
    output logic [IW-1:0]     c_index,
    output logic [ARR*AW-1:0] c_data_in,
    output logic [1:0]        dbg_state
);

    localparam int TCW = 16;
    localparam logic [7:0] ARR8 = 8'(ARR);

    tpu_state_e     r_state;
    tpu_state_e     w_state_nxt;
    logic [7:0]     r_k, r_m, r_n;
    logic [7:0]     r_mt_tiles, r_nt_tiles;
    logic [7:0]     r_mt, r_nt, r_row;
    logic [TCW-1:0] r_tc;
    logic           r_rd_vld;
    logic           r_done;
    logic           w_signed;

    logic           w_zero_dim;
    logic [7:0]     w_mt_tiles, w_nt_tiles;
    logic [7:0]     w_rows;
    logic           w_last_calc, w_last_row, w_last_mt, w_last_nt;
    logic           w_reading, w_clr;

    logic [DW-1:0]  w_a_lane [ARR];
    logic [DW-1:0]  w_b_lane [ARR];
    logic [DW-1:0]  w_a_h [ARR][ARR+1];
    logic [DW-1:0]  w_b_v [ARR+1][ARR];
    logic [AW-1:0]  w_acc [ARR][ARR];
    logic [ARR*DW-1:0] w_unused_a, w_unused_b;
    logic           w_unused;

    assign w_zero_dim  = (K == 8'd0) || (M == 8'd0) || (N == 8'd0);
    assign w_mt_tiles  = 8'(({1'b0, M} + 9'(ARR - 1)) / 9'(ARR));
    assign w_nt_tiles  = 8'(({1'b0, N} + 9'(ARR - 1)) / 9'(ARR));
    assign w_last_mt   = (r_mt == r_mt_tiles - 8'd1);
    assign w_last_nt   = (r_nt == r_nt_tiles - 8'd1);
    // The last row tile may be partial; rows beyond M are never written.
    assign w_rows      = w_last_mt ? (r_m - r_mt * ARR8) : ARR8;
    assign w_last_calc = (r_tc == TCW'(r_k) + TCW'(2 * ARR - 1));
    assign w_last_row  = (r_row == w_rows - 8'd1);
    assign w_reading   = (r_state == CALC) && (r_tc < TCW'(r_k));
    assign w_clr       = (r_state == CALC) && (r_tc == '0);

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign dbg_state = r_state;
    assign a_wr_en   = 1'b0;
    assign a_data_in = '0;
    assign b_wr_en   = 1'b0;
    assign b_data_in = '0;

`ifdef TPU_SIGNED_EN
    logic r_signed;

    // Operand signedness is fixed for the whole job at accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_signed <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_signed <= signed_mode;
        end
    end

    assign w_signed = r_signed;
`else
    assign w_signed = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus SRAM address / C write strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        a_index     = '0;
        b_index     = '0;
        c_wr_en     = 1'b0;
        c_index     = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_zero_dim ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_reading) begin
                    a_index = IW'(r_mt) * IW'(r_k) + IW'(r_tc);
                    b_index = IW'(r_nt) * IW'(r_k) + IW'(r_tc);
                end
                if (w_last_calc) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                c_wr_en = 1'b1;
                c_index = IW'(c_word_index(32'(r_nt), 32'(r_m), 32'(r_mt),
                                           32'(r_row), 32'(ARR)));
                if (w_last_row) begin
                    w_state_nxt = (w_last_mt && w_last_nt) ? DONE : CALC;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Job latches, tile/cycle/row counters, read-return flag and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k        <= '0;
            r_m        <= '0;
            r_n        <= '0;
            r_mt_tiles <= '0;
            r_nt_tiles <= '0;
            r_mt       <= '0;
            r_nt       <= '0;
            r_row      <= '0;
            r_tc       <= '0;
            r_rd_vld   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rd_vld <= w_reading;
            r_done   <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_k        <= K;
                        r_m        <= M;
                        r_n        <= N;
                        r_mt_tiles <= w_mt_tiles;
                        r_nt_tiles <= w_nt_tiles;
                        r_mt       <= '0;
                        r_nt       <= '0;
                        r_row      <= '0;
                        r_tc       <= '0;
                    end
                end
                CALC: begin
                    if (w_last_calc) begin
                        r_tc  <= '0;
                        r_row <= '0;
                    end else begin
                        r_tc <= r_tc + 1'b1;
                    end
                end
                WRITE: begin
                    if (w_last_row) begin
                        r_row <= '0;
                        if (w_last_nt) begin
                            r_nt <= '0;
                            r_mt <= r_mt + 8'd1;
                        end else begin
                            r_nt <= r_nt + 8'd1;
                        end
                    end else begin
                        r_row <= r_row + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Operand lanes: zero except when SRAM data for k = 0..K-1 returns;
    // lane i is delayed by i cycles so wavefronts meet in the grid.
    genvar gi, gr, gc;
    generate
        for (gi = 0; gi < ARR; gi++) begin : g_lane
            assign w_a_lane[gi] = r_rd_vld ? a_data_out[(ARR-1-gi)*DW +: DW] : '0;
            assign w_b_lane[gi] = r_rd_vld ? b_data_out[(ARR-1-gi)*DW +: DW] : '0;
            if (gi == 0) begin : g_nodly
                assign w_a_h[gi][0] = w_a_lane[gi];
                assign w_b_v[0][gi] = w_b_lane[gi];
            end else begin : g_dly
                logic [DW-1:0] r_a_sh [gi];
                logic [DW-1:0] r_b_sh [gi];

                // Skew shift buffer of depth gi for row/column gi.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int d = 0; d < gi; d++) begin
                            r_a_sh[d] <= '0;
                            r_b_sh[d] <= '0;
                        end
                    end else begin
                        r_a_sh[0] <= w_a_lane[gi];
                        r_b_sh[0] <= w_b_lane[gi];
                        for (int d = 1; d < gi; d++) begin
                            r_a_sh[d] <= r_a_sh[d-1];
                            r_b_sh[d] <= r_b_sh[d-1];
                        end
                    end
                end

                assign w_a_h[gi][0] = r_a_sh[gi-1];
                assign w_b_v[0][gi] = r_b_sh[gi-1];
            end
            assign w_unused_a[gi*DW +: DW] = w_a_h[gi][ARR];
            assign w_unused_b[gi*DW +: DW] = w_b_v[ARR][gi];
        end

        for (gr = 0; gr < ARR; gr++) begin : g_row
            for (gc = 0; gc < ARR; gc++) begin : g_col
                tpu_pe #(
                    .DW(DW),
                    .AW(AW)
                ) u_pe (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .i_clr   (w_clr),
                    .i_signed(w_signed),
                    .i_a     (w_a_h[gr][gc]),
                    .i_b     (w_b_v[gr][gc]),
                    .o_a     (w_a_h[gr][gc+1]),
                    .o_b     (w_b_v[gr+1][gc]),
                    .o_acc   (w_acc[gr][gc])
                );
            end
        end
    endgenerate

    // Operands leaving the far edges of the grid are not needed.
    assign w_unused = ^{w_unused_a, w_unused_b, r_n};

    // Select the accumulator row being written; element 0 in the MSBs.
    always_comb begin
        c_data_in = '0;
        if (r_state == WRITE) begin
            for (int r = 0; r < ARR; r++) begin
                if (r_row == 8'(r)) begin
                    for (int j = 0; j < ARR; j++) begin
                        c_data_in[(ARR-1-j)*AW +: AW] = w_acc[r][j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tpu_gemm_engine.sv
// Self-checking bench for tpu_gemm_engine: SRAM models, a golden GEMM
// model feeding an expected-write queue, and directed job sequences.
module tb_tpu_gemm_engine;

    localparam int ARR = 4;
    localparam int DW  = 8;
    localparam int AW  = 32;
    localparam int IW  = 16;
    localparam int EW  = IW + ARR * AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        k_i = '0, m_i = '0, n_i = '0;
    logic              busy, done;
    logic [IW-1:0]     a_index, b_index, c_index;
    logic [ARR*DW-1:0] a_data_out = '0, b_data_out = '0;
    logic [ARR*DW-1:0] a_data_in, b_data_in;
    logic              a_wr_en, b_wr_en, c_wr_en;
    logic [ARR*AW-1:0] c_data_in;
    logic [1:0]        dbg_state;
`ifdef TPU_SIGNED_EN
    logic              signed_mode = 1'b0;
`endif

    logic [ARR*DW-1:0] a_mem [0:1023];
    logic [ARR*DW-1:0] b_mem [0:1023];
    logic [7:0]        a_el [0:7][0:254];
    logic [7:0]        b_el [0:254][0:7];

    logic [EW-1:0]     exp_q[$];
    logic [EW-1:0]     got_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    tpu_gemm_engine #(.ARR(ARR), .DW(DW), .AW(AW), .IW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .K          (k_i),
        .M          (m_i),
        .N          (n_i),
`ifdef TPU_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .busy       (busy),
        .done       (done),
        .a_index    (a_index),
        .a_data_out (a_data_out),
        .a_wr_en    (a_wr_en),
        .a_data_in  (a_data_in),
        .b_index    (b_index),
        .b_data_out (b_data_out),
        .b_wr_en    (b_wr_en),
        .b_data_in  (b_data_in),
        .c_wr_en    (c_wr_en),
        .c_index    (c_index),
        .c_data_in  (c_data_in),
        .dbg_state  (dbg_state)
    );

    // Clock, cycle counter and synchronous-read SRAM models.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        a_data_out <= a_mem[a_index[9:0]];
        b_data_out <= b_mem[b_index[9:0]];
    end

    // Capture every C write as {index, row data}.
    always @(negedge clk) begin
        if (c_wr_en === 1'b1) got_q.push_back({c_index, c_data_in});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ext8(input logic [7:0] v, input bit sm);
        return sm ? {{24{v[7]}}, v} : {24'h0, v};
    endfunction

    // pat 0: 2*I both, 1: random, 2: all 0xFF, 3: A 0xFF / B 0x02
    task automatic fill(input int pat);
        for (int r = 0; r < 8; r++) begin
            for (int kk = 0; kk < 255; kk++) begin
                case (pat)
                    0: begin
                        a_el[r][kk] = (r == kk) ? 8'd2 : 8'd0;
                        b_el[kk][r] = (r == kk) ? 8'd2 : 8'd0;
                    end
                    1: begin
                        a_el[r][kk] = 8'($urandom_range(0, 255));
                        b_el[kk][r] = 8'($urandom_range(0, 255));
                    end
                    2: begin
                        a_el[r][kk] = 8'hFF;
                        b_el[kk][r] = 8'hFF;
                    end
                    default: begin
                        a_el[r][kk] = 8'hFF;
                        b_el[kk][r] = 8'h02;
                    end
                endcase
            end
        end
    endtask

    // Pack operands into tile layout and queue the golden C writes in order.
    task automatic prepare(input int m, input int k, input int n, input bit sm);
        int mtc, ntc, rows, row, col;
        logic [ARR*DW-1:0] w;
        logic [ARR*AW-1:0] d;
        logic [31:0] acc;
        mtc = (m + ARR - 1) / ARR;
        ntc = (n + ARR - 1) / ARR;
        for (int i = 0; i < 1024; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end
        for (int mt = 0; mt < mtc; mt++) begin
            for (int kk = 0; kk < k; kk++) begin
                w = '0;
                for (int i = 0; i < ARR; i++) begin
                    row = mt * ARR + i;
                    if (row < m) w[(ARR-1-i)*DW +: DW] = a_el[row][kk];
                end
                a_mem[mt * k + kk] = w;
            end
        end
        for (int nt = 0; nt < ntc; nt++) begin
            for (int kk = 0; kk < k; kk++) begin
                w = '0;
                for (int j = 0; j < ARR; j++) begin
                    col = nt * ARR + j;
                    if (col < n) w[(ARR-1-j)*DW +: DW] = b_el[kk][col];
                end
                b_mem[nt * k + kk] = w;
            end
        end
        exp_q.delete();
        got_q.delete();
        if (k > 0) begin
            for (int mt = 0; mt < mtc; mt++) begin
                for (int nt = 0; nt < ntc; nt++) begin
                    rows = (mt == mtc - 1) ? (m - mt * ARR) : ARR;
                    for (int r = 0; r < rows; r++) begin
                        d = '0;
                        for (int j = 0; j < ARR; j++) begin
                            col = nt * ARR + j;
                            acc = '0;
                            if (col < n) begin
                                for (int kk = 0; kk < k; kk++)
                                    acc = acc + ext8(a_el[mt*ARR+r][kk], sm) * ext8(b_el[kk][col], sm);
                            end
                            d[(ARR-1-j)*AW +: AW] = acc;
                        end
                        exp_q.push_back({IW'(nt * m + mt * ARR + r), d});
                    end
                end
            end
        end
    endtask

    // Launch a job, optionally re-pulse start mid-job, check timing and writes.
    task automatic run_job(input int m, input int k, input int n, input bit sm,
                           input int poke, input string tag);
        int mtc, ntc, t0, t_exp, t_done;
        bit seen;
        mtc = (m + ARR - 1) / ARR;
        ntc = (n + ARR - 1) / ARR;
        @(negedge clk);
        m_i = 8'(m);
        k_i = 8'(k);
        n_i = 8'(n);
`ifdef TPU_SIGNED_EN
        signed_mode = sm;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        chk({tag, "_busy_rise"}, EW'(busy), EW'(1));
        if (k == 0 || m == 0 || n == 0) t_exp = t0 + 1;
        else t_exp = t0 + mtc * ntc * (k + 2 * ARR) + ntc * m + 1;
        seen = 0;
        t_done = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (i == poke) begin
                start = 1'b1;
                k_i = 8'd0;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                seen = 1;
                t_done = cyc;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, EW'(seen), EW'(1));
        chk({tag, "_done_cycle"}, EW'(t_done), EW'(t_exp));
        chk({tag, "_busy_fall"}, EW'(busy), EW'(0));
        @(negedge clk);
        chk({tag, "_done_pulse"}, EW'(done), EW'(0));
        chk({tag, "_n_writes"}, EW'(got_q.size()), EW'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, "_wr"}, got_q.pop_front(), exp_q.pop_front());
    endtask

    initial begin
        bit seen;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", EW'(busy), EW'(0));
        chk("rst_done", EW'(done), EW'(0));
        chk("rst_c_wr_en", EW'(c_wr_en), EW'(0));
        chk("rst_a_index", EW'(a_index), EW'(0));
        chk("rst_b_index", EW'(b_index), EW'(0));
        chk("rst_c_index", EW'(c_index), EW'(0));
        chk("rst_c_data", EW'(c_data_in), EW'(0));
        chk("rst_tieoff", EW'({a_wr_en, b_wr_en, a_data_in, b_data_in}), EW'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4x4x4 with A = B = 2*I
        fill(0);
        prepare(4, 4, 4, 0);
        run_job(4, 4, 4, 0, -1, "ident");

        // Partial edge tiles, random unsigned operands
        fill(1);
        prepare(6, 3, 5, 0);
        run_job(6, 3, 5, 0, -1, "edge");

        // Maximum K with all-ones operands
        fill(2);
        prepare(4, 255, 4, 0);
        run_job(4, 255, 4, 0, -1, "kmax");

        // A = 0xFF, B = 0x02: -8 signed, 2040 unsigned
        fill(3);
`ifdef TPU_SIGNED_EN
        prepare(4, 4, 4, 1);
        run_job(4, 4, 4, 1, -1, "signed");
`endif
        prepare(4, 4, 4, 0);
        run_job(4, 4, 4, 0, -1, "unsigned_ff");

        // start re-pulsed while busy must be ignored
        fill(1);
        prepare(5, 6, 3, 0);
        run_job(5, 6, 3, 0, 7, "busy_start");

        // Zero-dimension jobs
        prepare(4, 0, 4, 0);
        run_job(4, 0, 4, 0, -1, "k0");
        prepare(0, 3, 4, 0);
        run_job(0, 3, 4, 0, -1, "m0");

        // Reset during WRITE, then a fresh job
        fill(1);
        prepare(4, 4, 4, 0);
        @(negedge clk);
        m_i = 8'd4;
        k_i = 8'd4;
        n_i = 8'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (c_wr_en === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("mid_rst_in_write", EW'(seen), EW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", EW'(busy), EW'(0));
        chk("mid_rst_c_wr_en", EW'(c_wr_en), EW'(0));
        got_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_writes", EW'(got_q.size()), EW'(0));
        chk("mid_rst_idle", EW'(busy), EW'(0));
        fill(1);
        prepare(4, 4, 4, 0);
        run_job(4, 4, 4, 0, -1, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tpu_gemm_engine.md
# tpu_gemm_engine

Parametrised output-stationary systolic GEMM engine computing C = A x B for A (M x K) and B (K x N) held in tile-packed SRAMs. It is the next-generation matrix unit in the accelerator datapath, with configurable array edge, operand and accumulator widths, and a start/done handshake. It also handles partial edge tiles exactly and supports an optional signed-operand mode. The block is an SRAM master only: it never writes A or B and never reads C.

## Interface
- ARR, 4: systolic array edge; array is ARR x ARR PEs, ARR >= 2
- DW, 8: operand element width
- AW, 32: accumulator / C element width, AW >= 2*DW
- IW, 16: SRAM index width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  job request; sampled only in IDLE
- K, M, N  in  8 each  matrix dimensions, latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at job completion
- a_index  out  IW  A word address; a_data_out in ARR*DW; A write port tied off (wr_en 0, data_in 0)
- b_index  out  IW  B word address; b_data_out in ARR*DW; B write port tied off
- c_wr_en  out  1  C write strobe
- c_index  out  IW  C word address
- c_data_in  out  ARR*AW  C row, element 0 in the MSBs
- signed_mode  in  1  present only with TPU_SIGNED_EN

## Operation
- Layout: A word mt*K+k holds A[mt*ARR+i][k] for i = 0..ARR-1, element i at bits [(ARR-1-i)*DW +: DW]. B word nt*K+k holds B[k][nt*ARR+j]. C word nt*M + mt*ARR + r holds row r of output tile (mt, nt).
- Tile counts: MT = ceil(M/ARR), NT = ceil(N/ARR). Tiles run nt-inner, mt-outer.
- FSM states:
  - IDLE: on start -> CALC. If any of K, M, N is 0 -> DONE instead.
  - CALC: tile_cycle runs 0..K+2*ARR-1. Reads are issued at tile_cycle < K with k = tile_cycle. At the last tile_cycle -> WRITE.
  - WRITE: one C row per cycle, r = 0..R-1. R = ARR, except for the last row tile (mt = MT-1), where R = M - mt*ARR. Then -> CALC for the next tile, or -> DONE after the final tile.
  - DONE: one cycle; done = 1 -> IDLE.
- Skew: SRAM data returns one cycle after issue. Row/column i is delayed i extra cycles through a shift buffer. Lanes are zero outside tile_cycle 1..K.
- PE: acc += ext(a)*ext(b). ext is zero-extension by default. Products are taken modulo 2^AW (wrap, no saturation).
- Accumulators clear synchronously in the cycle after the last WRITE, i.e. tile_cycle 0 of the next tile.
- Columns beyond N in the last column tile compute on zero-padded B and are written as stored. Rows beyond M are never written.
- start while busy is ignored.
- Reset mid-job: all state returns to IDLE, accumulators are zeroed, and no further C writes occur.
- Reset values: busy 0, done 0, c_wr_en 0, all indices 0, c_data_in 0.

## Timing
- Accepted start at edge T: busy = 1 from T+1. The first a_index/b_index for k = 0 is presented at T+1.
- Per tile: K+2*ARR CALC cycles + R WRITE cycles. No idle cycle between tiles.
- c_wr_en, c_index and c_data_in are combinational from the state/counters and are valid in the same cycle.
- done and the busy fall both occur in the cycle after the final write.
- Zero-dimension job: busy for 1 cycle, done at T+2, no writes.

## Configuration
- TPU_SIGNED_EN defined:
  - adds the signed_mode port;
  - when signed_mode is latched high at start, operands are two's-complement and sign-extended before the multiply.
- TPU_SIGNED_EN undefined: no port; all operands are unsigned.

## Structure
- Package tpu_pkg holds:
  - the FSM state enum (IDLE, CALC, WRITE, DONE);
  - default ARR/DW/AW/IW constants;
  - a C-index helper function.
- Sub-module tpu_pe: one MAC cell with clear, right/down operand forwarding registers and accumulator. It is instantiated ARR*ARR times via generate.

## Test plan
- ARR=4, M=K=N=4, A = B = identity-scaled by 2 -> four C writes at indices 0..3, diagonal 4, off-diagonal 0; done at cycle 13+4+1 after start.
- M=6, N=5, K=3, random unsigned -> MT = NT = 2. Writes: tile (0,0) rows 0..3; tile (0,1) at 6..9; tile (1,0) rows 0..1 at indices 4,5; tile (1,1) at 10,11. Values match the golden model.
- K=255, all operands 0xFF -> every C element = 255*255*255 = 16581375.
- TPU_SIGNED_EN, signed_mode=1, A all 0xFF (-1), B all 0x02, K=4 -> every element = -8 (0xFFFFFFF8).
- start pulsed during busy, and K=0 job -> the second start is ignored; the K=0 job gives done 2 cycles after start with no c_wr_en.
- rst_n asserted mid-WRITE -> busy 0 and c_wr_en 0 immediately; a fresh 4x4x4 job afterwards produces correct results, with no stale accumulation.
